sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Sequences and shares the board's single asynchronous 16-bit SRAM between two requesters. Port 0 is the CPU MDR/MAR memory path; port 1 is a debug/loader port that preloads programs and peeks memory. The block owns the active-low SRAM strobes (CE, UB, LB, OE, WE), ADDR and the bidirectional Data bus. It serialises accesses through a fixed-timing state machine with round-robin arbitration.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
WAIT_CYCLES, 2, cycles spent in ACCESS per transfer; must be >=1, and 0 fails an elaboration assertion

Ports:
Clk  in  1  system clock; all state is updated on its rising edge
Reset  in  1  asynchronous, active-low reset
p0_req, p1_req  in  1  access request; held high until ack
p0_we, p1_we  in  1  1=write, 0=read
p0_addr, p1_addr  in  ADDR_W  word address
p0_wdata, p1_wdata  in  DATA_W  write data
p0_be, p1_be  in  2  byte enables, [1]=upper byte, [0]=lower byte
p0_ack, p1_ack  out  1  one-cycle completion pulse
p0_rdata, p1_rdata  out  DATA_W  registered read data
CE, UB, LB, OE, WE  out  1  SRAM strobes, active-low
ADDR  out  ADDR_W  SRAM address
Data  inout  DATA_W  SRAM data bus

Behaviour:
- Reset (asserted low, acts asynchronously):
  - state=IDLE; CE=UB=LB=OE=WE=1; ADDR=0; Data=Z.
  - acks=0; rdata=0; last_grant=1, so port 0 wins the first tie.
- Requester contract: addr/we/wdata/be are stable from req rise until ack. Dropping req before ack does not abort the access; it completes and ack still pulses.
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> HOLD -> IDLE.
- IDLE:
  - Strobes high, Data=Z.
  - If any req is high at the edge, latch the winner's operands into internal registers and go to SETUP.
- SETUP:
  - ADDR=latched address; CE=0; UB/LB=~be.
  - Read: OE=0.
  - Write: Data is driven with wdata; WE stays 1.
- ACCESS:
  - Same as SETUP, except a write drives WE=0.
  - A down-counter loads WAIT_CYCLES-1 on entry and the state exits when it reaches 0.
  - Read: Data is sampled into the winner's rdata at the edge leaving the final ACCESS cycle.
- HOLD:
  - WE=1, OE=1; CE stays 0; ADDR held.
  - Write: Data is still driven for hold time.
  - The winner's ack=1 for exactly this cycle.
  - last_grant is updated to the winner.
- Latency: req sampled at edge t gives ack high during cycle t+2+WAIT_CYCLES. There is one mandatory IDLE turnaround cycle between transfers, so Data is never driven by the block while OE is low.
- Arbitration (evaluated only in IDLE):
  - Single request: that port wins.
  - Both requesting: the port != last_grant wins.
  - The grant is locked until HOLD ends.
- be=00:
  - Read: treated as 11.
  - Write: goes through the FSM with WE held 1, a no-op, and ack still pulses.
- rdata holds its value until that port's next read completes. Writes do not alter rdata.
- A req held high after its ack starts a new transfer at the next IDLE.
- Reset asserted mid-transfer: immediate return to reset values, the transfer is aborted and no ack is issued.

Optional Feature:
SRAM_ARB_FIXED_PRIO_EN:
- Defined: port 0 always wins ties, and last_grant is not used.
- Undefined: round-robin as described above.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, SETUP, ACCESS, HOLD}
  - typedef logic port_sel_t
  - constants SRAM_ADDR_W=20, SRAM_DATA_W=16
- Sub-module rr_arbiter2: 2-way arbiter containing the last_grant register and the SRAM_ARB_FIXED_PRIO_EN option. Inputs are req[1:0], an update strobe and Clk/Reset; output is the grant index.
- The top level instantiates rr_arbiter2, the FSM, the wait counter and the tristate Data driver.

Test Plan:
1. Reset low mid-ACCESS of a p0 write -> all strobes 1, Data=Z, p0_ack never pulses; after release, p0 still requesting -> transfer restarts from SETUP.
2. p0 write addr=0x00003, wdata=0xBEEF, be=11, then p0 read of the same address (SRAM model) -> WE low for exactly 2 cycles, p0_ack at t+4, p0_rdata=0xBEEF on the read ack.
3. p1 write addr=0x0000F, be=01, wdata=0x12AB over an existing 0xFFFF -> UB=1, LB=0; a subsequent p1 read returns 0xFFAB.
4. p0_req and p1_req rise on the same edge, both held for 4 transfers -> ack order p0, p1, p0, p1, with one IDLE cycle between transfers. With SRAM_ARB_FIXED_PRIO_EN defined -> p0, p0, p0, p0 until p0 drops.
5. p1 read whose req drops during SETUP -> transfer completes, p1_ack pulses once, rdata updated, no second transfer.
6. WAIT_CYCLES=4 build, single read -> OE low for 5 cycles (SETUP plus 4 ACCESS), ack at t+6.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} arb_state_t;

  typedef logic port_sel_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for both SRAM ports: master = requester, slave = arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);

  logic              p0_req,   p1_req;
  logic              p0_we,    p1_we;
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic [1:0]        p0_be,    p1_be;
  logic              p0_ack,   p1_ack;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_be, p1_be,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata
  );

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_be, p1_be,
    output p0_ack, p1_ack, p0_rdata, p1_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter holding last_grant; round-robin on ties.
// SRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties and last_grant is dropped.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic [1:0] req,
  input  logic      update,
  output port_sel_t grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign grant = ~req[0] & req[1];
`else
  port_sel_t last_grant_q, last_grant_d;

  always_comb begin
    grant        = (req == 2'b11) ? ~last_grant_q : req[1];
    last_grant_d = update ? grant : last_grant_q;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the CPU port (0) and the debug/loader port (1).
// Optional macro SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in rr_arbiter2.
//
// state  | meaning
// IDLE   | strobes high, bus released, arbitrate and latch winner operands
// SETUP  | CE/ADDR/byte lanes asserted; OE low for read, data driven for write
// ACCESS | WAIT_CYCLES cycles; WE low for a write, read data sampled on exit
// HOLD   | WE/OE high, CE and ADDR held, write data held, winner acked
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  sram_port_arbiter_if.slave req_if,
  output logic               CE,
  output logic               UB,
  output logic               LB,
  output logic               OE,
  output logic               WE,
  output logic [ADDR_W-1:0]  ADDR,
  inout  wire  [DATA_W-1:0]  Data
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_port_arbiter: WAIT_CYCLES must be at least 1");
  end

  arb_state_t        state_q, state_d;
  port_sel_t         gnt_q, gnt_d, arb_gnt;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        be_q, be_d, be_eff;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [1:0]        arb_req;
  logic              arb_update, busy;

  // In HOLD the arbiter sees only the winner, so its grant equals the winner for the update.
  assign arb_req    = (state_q == HOLD) ? (gnt_q ? 2'b10 : 2'b01)
                                        : {req_if.p1_req, req_if.p0_req};
  assign arb_update = (state_q == HOLD);

  rr_arbiter2 u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .req    (arb_req),
    .update (arb_update),
    .grant  (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_req != 2'b00) begin
          gnt_d   = arb_gnt;
          state_d = SETUP;
          if (arb_gnt) begin
            we_d = req_if.p1_we; addr_d = req_if.p1_addr;
            wdata_d = req_if.p1_wdata; be_d = req_if.p1_be;
          end else begin
            we_d = req_if.p0_we; addr_d = req_if.p0_addr;
            wdata_d = req_if.p0_wdata; be_d = req_if.p0_be;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (gnt_q) p1_rdata_d = Data;
            else       p0_rdata_d = Data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 2'b00;
      cnt_q      <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign busy = (state_q != IDLE);

  // A read with no lanes enabled reads the whole word; a write with none is a no-op.
  always_comb begin
    be_eff = (!we_q && be_q == 2'b00) ? 2'b11 : be_q;
    CE     = ~busy;
    UB     = ~(busy & be_eff[1]);
    LB     = ~(busy & be_eff[0]);
    OE     = ~(((state_q == SETUP) || (state_q == ACCESS)) & ~we_q);
    WE     = ~((state_q == ACCESS) & we_q & (|be_q));
  end

  assign ADDR = addr_q;
  assign Data = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};

  assign req_if.p0_ack   = (state_q == HOLD) && !gnt_q;
  assign req_if.p1_ack   = (state_q == HOLD) &&  gnt_q;
  assign req_if.p0_rdata = p0_rdata_q;
  assign req_if.p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small async SRAM model (WAIT_CYCLES=2 and 4).
module tb_sram_port_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus4 ();

  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic        CE4, UB4, LB4, OE4, WE4;
  logic [19:0] ADDR4;
  wire  [15:0] Data4;

  sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .req_if(bus),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
  );

  sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .req_if(bus4),
    .CE(CE4), .UB(UB4), .LB(LB4), .OE(OE4), .WE(WE4), .ADDR(ADDR4), .Data(Data4)
  );

  // Undriven bus reads as all ones.
  pullup (Data);

  logic [15:0] mem [0:255];
  assign Data  = (CE === 1'b0 && OE === 1'b0 && WE === 1'b1) ? mem[ADDR[7:0]] : 16'hzzzz;
  assign Data4 = (CE4 === 1'b0 && OE4 === 1'b0) ? 16'h5A3C : 16'hzzzz;

  always @(posedge WE) begin
    if (CE === 1'b0) begin
      if (!UB) mem[ADDR[7:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  <= Data[7:0];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int we_low, oe_low, ce_low, lat, nack, first;
  logic ub_s, lb_s;
  int who[4], at_cyc[4], exp_who[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit port, input bit we, input logic [19:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    if (!port) begin
      bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_be = be; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_be = be; bus.p1_req = 1'b1;
    end
  endtask

  task automatic drop(input bit port);
    if (!port) bus.p0_req = 1'b0;
    else       bus.p1_req = 1'b0;
  endtask

  // Counts falling edges until the port's ack; first sample is the SETUP cycle.
  task automatic wait_ack(input bit port, output int l);
    l = 0; we_low = 0; oe_low = 0; ce_low = 0;
    do begin
      @(negedge Clk);
      l++;
      if (l == 1) begin ub_s = UB; lb_s = LB; end
      if (!WE) we_low++;
      if (!OE) oe_low++;
      if (!CE) ce_low++;
    end while (!(port ? bus.p1_ack : bus.p0_ack) && l < 20);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[15] = 16'hFFFF;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_be = 2'b00;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_be = 2'b00;
    bus4.p0_req = 0; bus4.p0_we = 0; bus4.p0_addr = '0; bus4.p0_wdata = '0; bus4.p0_be = 2'b00;
    bus4.p1_req = 0; bus4.p1_we = 0; bus4.p1_addr = '0; bus4.p1_wdata = '0; bus4.p1_be = 2'b00;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_who = '{0, 0, 0, 0};
`else
    exp_who = '{0, 1, 0, 1};
`endif

    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst_ce", CE, 1); chk("rst_we", WE, 1); chk("rst_oe", OE, 1);
    chk("rst_ub", UB, 1); chk("rst_lb", LB, 1); chk("rst_addr", ADDR, 0);
    chk("rst_data", Data, 16'hFFFF); chk("rst_p0_rdata", bus.p0_rdata, 0);
    chk("rst_p0_ack", bus.p0_ack, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Test 1: reset during ACCESS of a p0 write, then restart
    issue(0, 1, 20'h00005, 16'h1234, 2'b11);
    @(negedge Clk);
    chk("t1_setup_ce", CE, 0); chk("t1_setup_we", WE, 1);
    chk("t1_setup_addr", ADDR, 20'h00005); chk("t1_setup_data", Data, 16'h1234);
    @(negedge Clk);
    chk("t1_access_we", WE, 0);
    Reset = 1'b0;
    #1;
    chk("t1_arst_ce", CE, 1); chk("t1_arst_we", WE, 1);
    chk("t1_arst_data", Data, 16'hFFFF); chk("t1_arst_addr", ADDR, 0);
    @(negedge Clk);
    chk("t1_no_ack", bus.p0_ack, 0);
    Reset = 1'b1;
    wait_ack(0, lat);
    chk("t1_restart_lat", lat, 4);
    drop(0);
    @(negedge Clk);
    chk("t1_mem", mem[5], 16'h1234);

    // Test 2: p0 write then read back
    issue(0, 1, 20'h00003, 16'hBEEF, 2'b11);
    wait_ack(0, lat);
    chk("t2_wr_lat", lat, 4); chk("t2_we_low", we_low, 2); chk("t2_wr_oe_low", oe_low, 0);
    drop(0);
    @(negedge Clk);
    issue(0, 0, 20'h00003, 16'h0000, 2'b11);
    wait_ack(0, lat);
    chk("t2_rd_lat", lat, 4); chk("t2_rd_data", bus.p0_rdata, 16'hBEEF);
    chk("t2_rd_oe_low", oe_low, 3); chk("t2_rd_we_low", we_low, 0);
    drop(0);
    @(negedge Clk);

    // Test 3: p1 lower-byte write over 0xFFFF, then read
    issue(1, 1, 20'h0000F, 16'h12AB, 2'b01);
    wait_ack(1, lat);
    chk("t3_ub", ub_s, 1); chk("t3_lb", lb_s, 0); chk("t3_wr_lat", lat, 4);
    drop(1);
    @(negedge Clk);
    issue(1, 0, 20'h0000F, 16'h0000, 2'b11);
    wait_ack(1, lat);
    chk("t3_rd_data", bus.p1_rdata, 16'hFFAB);
    chk("t3_p0_rdata_hold", bus.p0_rdata, 16'hBEEF);
    drop(1);
    @(negedge Clk);

    // Test 4: simultaneous requests held for four transfers
    for (int i = 0; i < 4; i++) begin who[i] = -1; at_cyc[i] = -1; end
    nack = 0;
    issue(0, 0, 20'h00003, 16'h0000, 2'b11);
    issue(1, 0, 20'h0000F, 16'h0000, 2'b11);
    for (int c = 1; c <= 30 && nack < 4; c++) begin
      @(negedge Clk);
      if (bus.p0_ack || bus.p1_ack) begin
        who[nack] = bus.p1_ack ? 1 : 0;
        at_cyc[nack] = c;
        nack++;
      end
    end
    drop(0); drop(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_who%0d", i), who[i], exp_who[i]);
      chk($sformatf("t4_cyc%0d", i), at_cyc[i], 4 + 5 * i);
    end
    @(negedge Clk);

    // Test 5: p1 read with req dropped during SETUP
    issue(1, 0, 20'h00003, 16'h0000, 2'b11);
    @(negedge Clk);
    chk("t5_setup_oe", OE, 0);
    drop(1);
    nack = 0; first = -1; ce_low = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (bus.p1_ack) begin nack++; if (first < 0) first = c; end
      if (!CE) ce_low++;
    end
    chk("t5_ack_count", nack, 1); chk("t5_ack_cyc", first, 3);
    chk("t5_ce_low", ce_low, 3); chk("t5_rdata", bus.p1_rdata, 16'hBEEF);

    // be=00 write is a no-op that still acks
    issue(0, 1, 20'h00003, 16'h0000, 2'b00);
    wait_ack(0, lat);
    chk("t7_lat", lat, 4); chk("t7_we_low", we_low, 0);
    drop(0);
    @(negedge Clk);
    chk("t7_mem", mem[3], 16'hBEEF);

    // Test 6: WAIT_CYCLES=4 read
    bus4.p0_we = 0; bus4.p0_addr = 20'h00007; bus4.p0_be = 2'b11; bus4.p0_req = 1'b1;
    lat = 0; oe_low = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (!OE4) oe_low++;
    end while (!bus4.p0_ack && lat < 20);
    bus4.p0_req = 1'b0;
    chk("t6_lat", lat, 6); chk("t6_oe_low", oe_low, 5);
    chk("t6_rdata", bus4.p0_rdata, 16'h5A3C);
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
